// File: rtl/iso7816_rx_sequencer.sv
// ISO7816 receive sequencer: acknowledges receiver flags, drives T=0 error
// signals on parity errors, delivers bytes on valid/ready and supervises waiting time.
module iso7816_rx_sequencer #(
   parameter int CLOCK_PER_BIT_WIDTH = 13,
   parameter int WT_WIDTH            = 24,
   parameter int RETRY_WIDTH         = 3
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           enable,
   input  logic [CLOCK_PER_BIT_WIDTH-1:0] clocksPerBit,
   input  logic                           errSigEnable,
   input  logic                           errSig2Etu,
   input  logic [RETRY_WIDTH-1:0]         maxRetry,
   input  logic [WT_WIDTH-1:0]            waitTime,
   input  logic                           clearStatus,
   input  logic [7:0]                     rxDataOut,
   input  logic                           rxDataOutReadyFlag,
   input  logic                           rxFrameErrorFlag,
   input  logic                           rxOverrunErrorFlag,
   input  logic                           rxEndOfRx,
   input  logic                           rxStartBit,
   output logic                           rxAckFlags,
   output logic                           ioDriveLow,
   output logic [7:0]                     outData,
   output logic                           outParityError,
   output logic                           outValid,
   input  logic                           outReady,
   output logic [RETRY_WIDTH-1:0]         retryCount,
   output logic                           overrunSticky,
   output logic                           timeoutSticky,
   output logic                           timeoutPulse,
   output logic                           busy
);

   typedef enum logic [2:0] {IDLE, RX, CHECK, ERRWAIT, ERRSIG, DELIVER} state_t;

   localparam logic [CLOCK_PER_BIT_WIDTH:0] ETU_ONE   = 1;
   localparam logic [WT_WIDTH-1:0]          WT_ONE    = 1;
   localparam logic [RETRY_WIDTH-1:0]       RETRY_ONE = 1;

   state_t                         r_state;
   logic [CLOCK_PER_BIT_WIDTH:0]   r_etuCnt;
   logic [WT_WIDTH-1:0]            r_wtCnt;

   logic [CLOCK_PER_BIT_WIDTH-1:0] w_half;
   logic [CLOCK_PER_BIT_WIDTH:0]   w_sigLen;
   logic [CLOCK_PER_BIT_WIDTH:0]   w_etuNext;
   logic [WT_WIDTH-1:0]            w_wtNext;
   logic                           w_anyFlag;

   // One extra counter bit lets a 2-etu error signal at the largest etu fit without wrapping.
   assign w_half    = clocksPerBit >> 1;
   assign w_sigLen  = errSig2Etu ? {clocksPerBit, 1'b0} : {1'b0, clocksPerBit};
   assign w_etuNext = r_etuCnt + ETU_ONE;
   assign w_wtNext  = r_wtCnt + WT_ONE;
   assign w_anyFlag = rxDataOutReadyFlag | rxFrameErrorFlag | rxOverrunErrorFlag;

   assign rxAckFlags = (r_state == CHECK) && w_anyFlag;
   assign busy       = (r_state != IDLE);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state        <= IDLE;
         r_etuCnt       <= '0;
         r_wtCnt        <= '0;
         ioDriveLow     <= 1'b0;
         outData        <= '0;
         outParityError <= 1'b0;
         outValid       <= 1'b0;
         retryCount     <= '0;
         overrunSticky  <= 1'b0;
         timeoutSticky  <= 1'b0;
         timeoutPulse   <= 1'b0;
      end else begin
         timeoutPulse <= 1'b0;
         // Clearing comes first so that a set in the same cycle takes precedence.
         if (clearStatus) begin
            overrunSticky <= 1'b0;
            timeoutSticky <= 1'b0;
         end

         if (!enable || r_state != IDLE || rxStartBit || waitTime == '0) begin
            r_wtCnt <= '0;
         end else if (r_wtCnt < waitTime) begin
            r_wtCnt <= w_wtNext;
            if (w_wtNext == waitTime) begin
               timeoutPulse  <= 1'b1;
               timeoutSticky <= 1'b1;
            end
         end

         if (!enable) begin
            r_state    <= IDLE;
            r_etuCnt   <= '0;
            ioDriveLow <= 1'b0;
            outValid   <= 1'b0;
            retryCount <= '0;
         end else begin
            case (r_state)
               IDLE: begin
                  if (rxStartBit) r_state <= RX;
               end
               RX: begin
                  if (rxEndOfRx) r_state <= CHECK;
               end
               CHECK: begin
                  r_etuCnt <= '0;
                  if (rxOverrunErrorFlag) overrunSticky <= 1'b1;
                  if (rxDataOutReadyFlag) begin
                     outData        <= rxDataOut;
                     outParityError <= 1'b0;
                     retryCount     <= '0;
                     outValid       <= 1'b1;
                     r_state        <= DELIVER;
                  end else if (rxFrameErrorFlag && errSigEnable && retryCount < maxRetry) begin
                     retryCount <= retryCount + RETRY_ONE;
                     if (w_half == '0) begin
                        ioDriveLow <= 1'b1;
                        r_state    <= ERRSIG;
                     end else begin
                        r_state    <= ERRWAIT;
                     end
                  end else if (rxFrameErrorFlag) begin
                     outData        <= rxDataOut;
                     outParityError <= 1'b1;
                     retryCount     <= '0;
                     outValid       <= 1'b1;
                     r_state        <= DELIVER;
                  end else begin
                     r_state <= IDLE;
                  end
               end
               ERRWAIT: begin
                  if (w_etuNext >= {1'b0, w_half}) begin
                     r_etuCnt   <= '0;
                     ioDriveLow <= 1'b1;
                     r_state    <= ERRSIG;
                  end else begin
                     r_etuCnt <= w_etuNext;
                  end
               end
               ERRSIG: begin
                  if (w_etuNext >= w_sigLen) begin
                     r_etuCnt   <= '0;
                     ioDriveLow <= 1'b0;
                     r_state    <= IDLE;
                  end else begin
                     r_etuCnt <= w_etuNext;
                  end
               end
               DELIVER: begin
                  if (outReady) begin
                     outValid <= 1'b0;
                     r_state  <= IDLE;
                  end
               end
               default: r_state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_iso7816_rx_sequencer.sv
// Self-checking bench for iso7816_rx_sequencer: directed scenarios plus
// randomized characters checked against a per-character behavioural model.
module tb_iso7816_rx_sequencer;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        enable = 1'b0;
   logic [12:0] clocksPerBit = 13'd372;
   logic        errSigEnable = 1'b1;
   logic        errSig2Etu = 1'b0;
   logic [2:0]  maxRetry = 3'd3;
   logic [23:0] waitTime = '0;
   logic        clearStatus = 1'b0;
   logic [7:0]  rxDataOut = '0;
   logic        rxDataOutReadyFlag = 1'b0;
   logic        rxFrameErrorFlag = 1'b0;
   logic        rxOverrunErrorFlag = 1'b0;
   logic        rxEndOfRx = 1'b0;
   logic        rxStartBit = 1'b0;
   logic        outReady = 1'b0;
   logic        rxAckFlags, ioDriveLow, outParityError, outValid;
   logic        overrunSticky, timeoutSticky, timeoutPulse, busy;
   logic [7:0]  outData;
   logic [2:0]  retryCount;

   int assertCount = 0;
   int failCount   = 0;
   int mRetry      = 0;
   logic mOverrun  = 1'b0;

   iso7816_rx_sequencer dut (
      .clk(clk), .reset(reset), .enable(enable), .clocksPerBit(clocksPerBit),
      .errSigEnable(errSigEnable), .errSig2Etu(errSig2Etu), .maxRetry(maxRetry),
      .waitTime(waitTime), .clearStatus(clearStatus), .rxDataOut(rxDataOut),
      .rxDataOutReadyFlag(rxDataOutReadyFlag), .rxFrameErrorFlag(rxFrameErrorFlag),
      .rxOverrunErrorFlag(rxOverrunErrorFlag), .rxEndOfRx(rxEndOfRx), .rxStartBit(rxStartBit),
      .rxAckFlags(rxAckFlags), .ioDriveLow(ioDriveLow), .outData(outData),
      .outParityError(outParityError), .outValid(outValid), .outReady(outReady),
      .retryCount(retryCount), .overrunSticky(overrunSticky), .timeoutSticky(timeoutSticky),
      .timeoutPulse(timeoutPulse), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      assertCount++;
      if (got !== exp) begin
         failCount++;
         $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic applyReset;
      reset = 1'b1;
      tick;
      tick;
      reset = 1'b0;
      mRetry = 0;
      mOverrun = 1'b0;
      checkOutput("rst_valid", outValid, 0);
      checkOutput("rst_drive", ioDriveLow, 0);
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_retry", retryCount, 0);
      checkOutput("rst_ovr", overrunSticky, 0);
      checkOutput("rst_tmo", timeoutSticky, 0);
      checkOutput("rst_pulse", timeoutPulse, 0);
      checkOutput("rst_ack", rxAckFlags, 0);
      checkOutput("rst_data", outData, 0);
      checkOutput("rst_perr", outParityError, 0);
   endtask

   // Emulates the receiver for one character; returns sampled in the CHECK cycle.
   task automatic applyStimulus(input logic [7:0] d, input logic rdy, input logic fe, input logic ov);
      rxStartBit = 1'b1;
      tick;
      rxStartBit = 1'b0;
      repeat (3) tick;
      rxEndOfRx = 1'b1;
      rxDataOut = d;
      rxDataOutReadyFlag = rdy;
      rxFrameErrorFlag = fe;
      rxOverrunErrorFlag = ov;
      tick;
      rxEndOfRx = 1'b0;
   endtask

   task automatic clearFlags;
      rxDataOutReadyFlag = 1'b0;
      rxFrameErrorFlag = 1'b0;
      rxOverrunErrorFlag = 1'b0;
   endtask

   task automatic processChar(input logic [7:0] d, input logic rdy, input logic fe,
                              input logic ov, input int readyDelay);
      int gap, hi, guard, expLen;
      logic sawValid;
      applyStimulus(d, rdy, fe, ov);
      checkOutput("ack", rxAckFlags, {31'd0, rdy | fe | ov});
      if (ov) mOverrun = 1'b1;
      tick;
      clearFlags;
      checkOutput("ovr_sticky", overrunSticky, {31'd0, mOverrun});
      if (rdy || (fe && !(errSigEnable && mRetry < int'(maxRetry)))) begin
         mRetry = 0;
         checkOutput("dlv_valid", outValid, 1);
         checkOutput("dlv_data", outData, {24'd0, d});
         checkOutput("dlv_perr", outParityError, {31'd0, !rdy});
         checkOutput("dlv_retry", retryCount, 0);
         repeat (readyDelay) tick;
         checkOutput("dlv_hold", {outValid, outData}, {23'd0, 1'b1, d});
         outReady = 1'b1;
         tick;
         outReady = 1'b0;
         checkOutput("dlv_done_valid", outValid, 0);
         checkOutput("dlv_done_busy", busy, 0);
      end else if (fe) begin
         mRetry++;
         expLen = errSig2Etu ? 2 * int'(clocksPerBit) : int'(clocksPerBit);
         gap = 0; hi = 0; guard = 0; sawValid = 1'b0;
         while (!ioDriveLow && guard < 20000) begin
            gap++; guard++;
            if (outValid) sawValid = 1'b1;
            tick;
         end
         while (ioDriveLow && guard < 20000) begin
            hi++; guard++;
            if (outValid) sawValid = 1'b1;
            tick;
         end
         checkOutput("err_gap", gap, int'(clocksPerBit) / 2);
         checkOutput("err_len", hi, expLen);
         checkOutput("err_novalid", sawValid, 0);
         checkOutput("err_idle", busy, 0);
         checkOutput("err_retry", retryCount, mRetry);
      end else begin
         checkOutput("none_idle", busy, 0);
         checkOutput("none_valid", outValid, 0);
      end
   endtask

   initial begin
      int pulses, pulseAt, kind, guard;
      logic ov;
      applyReset;
      enable = 1'b1;

      $display("[TB] good byte 0x3B");
      processChar(8'h3B, 1'b1, 1'b0, 1'b0, 5);

      $display("[TB] single parity error");
      processChar(8'h3B, 1'b0, 1'b1, 1'b0, 0);

      $display("[TB] four parity errors on 0xA5");
      applyReset;
      enable = 1'b1;
      for (int i = 0; i < 4; i++) processChar(8'hA5, 1'b0, 1'b1, 1'b0, 1);

      $display("[TB] 2 etu error signal at clocksPerBit=4095");
      clocksPerBit = 13'd4095;
      errSig2Etu = 1'b1;
      processChar(8'h5A, 1'b0, 1'b1, 1'b0, 0);
      errSig2Etu = 1'b0;
      clocksPerBit = 13'd372;

      $display("[TB] waiting time");
      enable = 1'b0;
      waitTime = 24'd1000;
      tick;
      enable = 1'b1;
      pulses = 0; pulseAt = 0;
      for (int k = 1; k <= 1100; k++) begin
         tick;
         if (timeoutPulse) begin pulses++; pulseAt = k; end
      end
      checkOutput("tmo_count", pulses, 1);
      checkOutput("tmo_at", pulseAt, 1000);
      checkOutput("tmo_sticky", timeoutSticky, 1);
      clearStatus = 1'b1;
      tick;
      clearStatus = 1'b0;
      checkOutput("tmo_clear", timeoutSticky, 0);

      enable = 1'b0;
      tick;
      enable = 1'b1;
      pulses = 0;
      for (int k = 1; k <= 998; k++) begin tick; if (timeoutPulse) pulses++; end
      rxStartBit = 1'b1;
      tick;
      rxStartBit = 1'b0;
      for (int k = 0; k < 10; k++) begin tick; if (timeoutPulse) pulses++; end
      rxEndOfRx = 1'b1;
      tick;
      rxEndOfRx = 1'b0;
      for (int k = 0; k < 20; k++) begin tick; if (timeoutPulse) pulses++; end
      checkOutput("tmo_startbit", pulses, 0);
      checkOutput("tmo_startbit_sticky", timeoutSticky, 0);
      waitTime = '0;

      $display("[TB] overrun sticky and clear");
      processChar(8'h11, 1'b0, 1'b0, 1'b1, 0);
      clearStatus = 1'b1;
      tick;
      clearStatus = 1'b0;
      mOverrun = 1'b0;
      checkOutput("ovr_clear", overrunSticky, 0);

      $display("[TB] randomized characters");
      for (int n = 0; n < 40; n++) begin
         clocksPerBit = 13'($urandom_range(1, 24));
         errSigEnable = ($urandom_range(0, 9) < 8);
         errSig2Etu = 1'($urandom_range(0, 1));
         maxRetry = 3'($urandom_range(0, 7));
         kind = $urandom_range(0, 9);
         ov = 1'($urandom_range(0, 3) == 0);
         if (kind < 4)      processChar(8'($urandom), 1'b1, 1'b0, ov, $urandom_range(0, 4));
         else if (kind < 8) processChar(8'($urandom), 1'b0, 1'b1, ov, $urandom_range(0, 4));
         else if (kind < 9) processChar(8'($urandom), 1'b0, 1'b0, 1'b1, 0);
         else               processChar(8'($urandom), 1'b0, 1'b0, 1'b0, 0);
      end

      $display("[TB] enable drop during delivery");
      applyStimulus(8'hC3, 1'b1, 1'b0, 1'b0);
      tick;
      clearFlags;
      checkOutput("abort_pre_valid", outValid, 1);
      enable = 1'b0;
      tick;
      checkOutput("abort_valid", outValid, 0);
      checkOutput("abort_busy", busy, 0);
      enable = 1'b1;
      mRetry = 0;

      $display("[TB] reset during error signal");
      clocksPerBit = 13'd372;
      errSigEnable = 1'b1;
      errSig2Etu = 1'b0;
      maxRetry = 3'd3;
      processChar(8'h22, 1'b0, 1'b0, 1'b1, 0);
      applyStimulus(8'h55, 1'b0, 1'b1, 1'b0);
      tick;
      clearFlags;
      guard = 0;
      while (!ioDriveLow && guard < 1000) begin tick; guard++; end
      repeat (10) tick;
      checkOutput("rst_mid_pre_drive", ioDriveLow, 1);
      reset = 1'b1;
      tick;
      checkOutput("rst_mid_drive", ioDriveLow, 0);
      checkOutput("rst_mid_busy", busy, 0);
      checkOutput("rst_mid_retry", retryCount, 0);
      checkOutput("rst_mid_ovr", overrunSticky, 0);
      checkOutput("rst_mid_tmo", timeoutSticky, 0);
      reset = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
